// File: rtl/led_breathe_pwm.sv
// led_breathe_pwm: LED driver with off/solid/breathe/blink modes and period-synchronous 8-bit PWM
module led_breathe_pwm #(
  parameter logic [7:0] STEP       = 8'd4,
  parameter logic [3:0] HOLD_TICKS = 4'd8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       tick_i,
  input  logic [1:0] mode_i,
  output logic       pwm_o,
  output logic [7:0] level_o,
  output logic [2:0] phase_o,
  output logic       period_o
);
  typedef enum logic [2:0] {IDLE = 3'd0, UP = 3'd1, HOLD_HI = 3'd2, DOWN = 3'd3, HOLD_LO = 3'd4} state_t;
  state_t     state, state_n;
  logic [7:0] lvl, lvl_n, pwm_cnt, act;
  logic [3:0] hold, hold_n;
  logic [1:0] mode_q;
  logic [8:0] sum;
  logic       mode_chg;
  assign level_o  = lvl;
  assign phase_o  = state;
  assign sum      = {1'b0, lvl} + {1'b0, STEP};
  assign mode_chg = mode_i != mode_q;
  // brightness/mode sequencing; a mode change wins over a same-cycle tick
  always_comb begin
    state_n = state;
    lvl_n   = lvl;
    hold_n  = hold;
    if (mode_i == 2'b00) begin
      state_n = IDLE;
      lvl_n   = 8'd0;
      hold_n  = 4'd0;
    end else if (mode_i == 2'b01) begin
      state_n = IDLE;
      lvl_n   = 8'hff;
    end else if (mode_i == 2'b11) begin
      state_n = IDLE;
      lvl_n   = mode_chg ? 8'd0 : tick_i ? ((lvl == 8'd0) ? 8'hff : 8'd0) : lvl;
    end else if (mode_chg || state == IDLE) begin
      state_n = UP;
      lvl_n   = 8'd0;
    end else if (tick_i) begin
      case (state)
        UP: begin
          state_n = (sum >= 9'd255) ? HOLD_HI : UP;
          lvl_n   = (sum >= 9'd255) ? 8'hff : sum[7:0];
          hold_n  = (sum >= 9'd255) ? HOLD_TICKS : hold;
        end
        DOWN: begin
          state_n = (lvl <= STEP) ? HOLD_LO : DOWN;
          lvl_n   = (lvl <= STEP) ? 8'd0 : lvl - STEP;
          hold_n  = (lvl <= STEP) ? HOLD_TICKS : hold;
        end
        HOLD_HI: begin
          state_n = (hold <= 4'd1) ? DOWN : HOLD_HI;
          hold_n  = (hold == 4'd0) ? 4'd0 : hold - 4'd1;
        end
        HOLD_LO: begin
          state_n = (hold <= 4'd1) ? UP : HOLD_LO;
          hold_n  = (hold == 4'd0) ? 4'd0 : hold - 4'd1;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  // state registers and PWM; duty reloads only at the period boundary, ena low freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lvl      <= 8'd0;
      hold     <= 4'd0;
      mode_q   <= 2'b00;
      pwm_cnt  <= 8'd0;
      act      <= 8'd0;
      pwm_o    <= 1'b0;
      period_o <= 1'b0;
    end else if (ena) begin
      state    <= state_n;
      lvl      <= lvl_n;
      hold     <= hold_n;
      mode_q   <= mode_i;
      pwm_cnt  <= pwm_cnt + 8'd1;
      act      <= (pwm_cnt == 8'hff) ? lvl : act;
      pwm_o    <= (act == 8'hff) || (pwm_cnt < act);
      period_o <= pwm_cnt == 8'hff;
    end else begin
      pwm_o    <= 1'b0;
      period_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_led_breathe_pwm.sv
// tb_led_breathe_pwm: directed self-checking bench for led_breathe_pwm
module tb_led_breathe_pwm;
  logic       clk = 1'b0;
  logic       rst_n, ena, tick_i;
  logic [1:0] mode_i;
  logic       pwm_o, period_o;
  logic [7:0] level_o;
  logic [2:0] phase_o;
  logic [7:0] mcnt;
  int         n_pass = 0, n_total = 0;
  int         hi, per;

  led_breathe_pwm dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tick_i(tick_i), .mode_i(mode_i),
    .pwm_o(pwm_o), .level_o(level_o), .phase_o(phase_o), .period_o(period_o)
  );

  always #5 clk = ~clk;

  // reference PWM counter position
  always @(posedge clk or negedge rst_n)
    if (!rst_n) mcnt <= 8'd0;
    else if (ena) mcnt <= mcnt + 8'd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick;
    tick_i = 1'b1;
    step(1);
    tick_i = 1'b0;
    step(1);
  endtask

  task automatic tick_exp(input string tag, input logic [7:0] l, input logic [2:0] p);
    do_tick;
    chk({tag, "_lvl"}, level_o, l);
    chk({tag, "_phase"}, phase_o, p);
  endtask

  task automatic wait_cnt(input logic [7:0] v);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (mcnt != v && n < 600);
    if (mcnt != v) chk("wait_cnt_timeout", mcnt, v);
  endtask

  // land just after a duty reload, with pwm_o showing counter position 0
  task automatic sync_period;
    wait_cnt(8'd0);
    wait_cnt(8'd1);
  endtask

  task automatic count_window(input int tick_at);
    hi = 0;
    per = 0;
    for (int i = 0; i < 256; i++) begin
      hi += pwm_o;
      per += period_o;
      tick_i = (i == tick_at);
      step(1);
      tick_i = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; tick_i = 1'b0; mode_i = 2'b00;
    step(3);
    chk("rst_pwm", pwm_o, 0);
    chk("rst_lvl", level_o, 0);
    chk("rst_phase", phase_o, 0);
    chk("rst_period", period_o, 0);
    rst_n = 1'b1;
    step(255);
    chk("period_early", period_o, 0);
    step(1);
    chk("period_first", period_o, 1);
    step(1);
    chk("period_once", period_o, 0);
    mode_i = 2'b01;
    step(1);
    chk("solid_lvl", level_o, 255);
    chk("solid_phase", phase_o, 0);
    sync_period;
    hi = 0; per = 0;
    for (int i = 0; i < 256; i++) begin
      hi += pwm_o;
      per += period_o;
      tick_i = (i % 16 == 0);
      step(1);
    end
    tick_i = 1'b0;
    chk("solid_duty", hi, 256);
    chk("solid_periods", per, 1);
    chk("solid_ignore_tick", level_o, 255);
    mode_i = 2'b11; tick_i = 1'b1;
    step(1);
    tick_i = 1'b0;
    chk("blink_entry_lvl", level_o, 0);
    chk("blink_phase", phase_o, 0);
    do_tick;
    chk("blink_on", level_o, 255);
    do_tick;
    chk("blink_off", level_o, 0);
    mode_i = 2'b00;
    step(1);
    chk("off_lvl", level_o, 0);
    mode_i = 2'b10;
    step(1);
    chk("breathe_entry_phase", phase_o, 1);
    chk("breathe_entry_lvl", level_o, 0);
    repeat (16) do_tick;
    chk("ramp64", level_o, 64);
    sync_period;
    count_window(100);
    chk("duty64", hi, 64);
    chk("duty64_period", per, 1);
    count_window(-1);
    chk("duty68_after_wrap", hi, 68);
    mode_i = 2'b00;
    step(1);
    mode_i = 2'b10;
    step(1);
    for (int k = 1; k <= 63; k++) tick_exp("up", 8'(4 * k), 3'd1);
    tick_exp("up_top", 8'd255, 3'd2);
    repeat (7) tick_exp("hold_hi", 8'd255, 3'd2);
    tick_exp("hold_hi_exit", 8'd255, 3'd3);
    for (int j = 1; j <= 63; j++) tick_exp("down", 8'(255 - 4 * j), 3'd3);
    tick_exp("down_bottom", 8'd0, 3'd4);
    repeat (7) tick_exp("hold_lo", 8'd0, 3'd4);
    tick_exp("hold_lo_exit", 8'd0, 3'd1);
    tick_exp("up_again", 8'd4, 3'd1);
    repeat (9) do_tick;
    chk("pre_prio_lvl", level_o, 40);
    tick_i = 1'b1; mode_i = 2'b00;
    step(1);
    tick_i = 1'b0;
    chk("prio_lvl", level_o, 0);
    chk("prio_phase", phase_o, 0);
    mode_i = 2'b10;
    step(1);
    repeat (72) do_tick;
    repeat (32) do_tick;
    chk("down_127_lvl", level_o, 127);
    chk("down_127_phase", phase_o, 3);
    ena = 1'b0; hi = 0; per = 0;
    for (int i = 0; i < 100; i++) begin
      tick_i = (i % 4 == 0);
      step(1);
      hi += pwm_o;
      per += period_o;
    end
    tick_i = 1'b0;
    chk("freeze_pwm", hi, 0);
    chk("freeze_period", per, 0);
    chk("freeze_lvl", level_o, 127);
    chk("freeze_phase", phase_o, 3);
    ena = 1'b1;
    do_tick;
    chk("resume_lvl", level_o, 123);
    chk("resume_phase", phase_o, 3);
    mode_i = 2'b00;
    step(1);
    mode_i = 2'b10;
    step(1);
    repeat (67) do_tick;
    chk("hold_hi_lvl", level_o, 255);
    chk("hold_hi_phase", phase_o, 2);
    sync_period;
    step(1);
    chk("hold_hi_pwm", pwm_o, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", pwm_o, 0);
    chk("async_rst_lvl", level_o, 0);
    chk("async_rst_phase", phase_o, 0);
    chk("async_rst_period", period_o, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("restart_phase", phase_o, 1);
    chk("restart_lvl", level_o, 0);
    do_tick;
    chk("restart_step", level_o, 4);
    mode_i = 2'b01;
    step(1);
    do_tick;
    chk("solid_tick_lvl", level_o, 255);
    chk("solid_tick_phase", phase_o, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
